// File: rtl/pipelined_shifter_if.sv
// Operation/result handshake bundle for the pipelined barrel shifter.
// The master presents operations and consumes results; the slave is the shifter.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_mode;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_zero;
  logic             out_neg;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_zero, out_neg, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_zero, out_neg, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: LSL/LSR/ASR/ROR/ROL/RRX with ARM-style carry-out.
// The first stage decodes mode and amount into a plain (direction, fill,
// amount<WIDTH) shift plus a final carry; the log2(WIDTH) mux levels are then
// spread over STAGES registers, earliest stages taking any extra level.
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_shifter_if.slave bus
);
  localparam int LOG = $clog2(WIDTH);

  localparam logic [1:0] FILL_ZERO = 2'd0;
  localparam logic [1:0] FILL_SIGN = 2'd1;
  localparam logic [1:0] FILL_ROT  = 2'd2;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;
  localparam logic [2:0] MODE_RRX = 3'd5;

  localparam logic [LOG-1:0] ONE_L = LOG'(1);

  // First mux level handled by stage s; stage s covers [lvl_lo(s), lvl_lo(s+1)).
  function automatic int lvl_lo(input int s);
    return s * (LOG / STAGES) + ((s < (LOG % STAGES)) ? s : (LOG % STAGES));
  endfunction

  // One mux level: shift/rotate by sh in the decoded direction with the decoded fill.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] x,
    input int               sh,
    input logic             dir_left,
    input logic [1:0]       fill
  );
    logic [WIDTH-1:0] r;
    if (dir_left)
      r = (fill == FILL_ROT) ? ((x << sh) | (x >> (WIDTH - sh))) : (x << sh);
    else if (fill == FILL_ROT)
      r = (x >> sh) | (x << (WIDTH - sh));
    else if (fill == FILL_SIGN)
      r = WIDTH'($signed(x) >>> sh);
    else
      r = x >> sh;
    return r;
  endfunction

  logic adv;
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  // Decode outputs
  logic [WIDTH-1:0] dec_data;
  logic [LOG-1:0]   dec_amt;
  logic             dec_left;
  logic [1:0]       dec_fill;
  logic             dec_cout;
  logic [LOG-1:0]   n_lo;
  logic [LOG-1:0]   idx_l;
  logic [LOG-1:0]   idx_r;
  logic             n_zero;
  logic             n_eq_w;
  logic             n_gt_w;

  // Decode: saturation and zero-amount cases, effective amount, carry bit.
  // idx_l = (W-n) mod W selects in[W-n] (and in[0] when n==W or r==0);
  // idx_r = (n-1) mod W selects in[n-1] (and in[W-1] when n==W or r==0).
  always_comb begin
    n_lo     = bus.in_amt[LOG-1:0];
    idx_l    = '0 - n_lo;
    idx_r    = n_lo - ONE_L;
    n_zero   = (bus.in_amt == '0);
    n_eq_w   = (bus.in_amt == AMT_W'(WIDTH));
    n_gt_w   = (bus.in_amt >  AMT_W'(WIDTH));
    dec_data = bus.in_data;
    dec_amt  = '0;
    dec_left = 1'b0;
    dec_fill = FILL_ZERO;
    dec_cout = bus.in_cin;
    case (bus.in_mode)
      MODE_LSL: begin
        if (n_gt_w) begin
          dec_data = '0;
          dec_cout = 1'b0;
        end else if (n_eq_w) begin
          dec_data = '0;
          dec_cout = bus.in_data[0];
        end else if (!n_zero) begin
          dec_amt  = n_lo;
          dec_left = 1'b1;
          dec_cout = bus.in_data[idx_l];
        end
      end
      MODE_LSR: begin
        if (n_gt_w) begin
          dec_data = '0;
          dec_cout = 1'b0;
        end else if (n_eq_w) begin
          dec_data = '0;
          dec_cout = bus.in_data[WIDTH-1];
        end else if (!n_zero) begin
          dec_amt  = n_lo;
          dec_cout = bus.in_data[idx_r];
        end
      end
      MODE_ASR: begin
        if (n_eq_w || n_gt_w) begin
          dec_data = {WIDTH{bus.in_data[WIDTH-1]}};
          dec_cout = bus.in_data[WIDTH-1];
        end else if (!n_zero) begin
          dec_amt  = n_lo;
          dec_fill = FILL_SIGN;
          dec_cout = bus.in_data[idx_r];
        end
      end
      MODE_ROR: begin
        if (!n_zero) begin
          dec_amt  = n_lo;
          dec_fill = FILL_ROT;
          dec_cout = bus.in_data[idx_r];
        end
      end
      MODE_ROL: begin
        if (!n_zero) begin
          dec_amt  = n_lo;
          dec_left = 1'b1;
          dec_fill = FILL_ROT;
          dec_cout = bus.in_data[idx_l];
        end
      end
      MODE_RRX: begin
        dec_data = {bus.in_cin, bus.in_data[WIDTH-1:1]};
        dec_cout = bus.in_data[0];
      end
      default: ;
    endcase
  end

  // Links between stages: index 0 is the decode output, index s+1 is stage s.
  logic             link_valid [STAGES+1];
  logic [WIDTH-1:0] link_data  [STAGES+1];
  logic             link_cout  [STAGES+1];
  logic [TAG_W-1:0] link_tag   [STAGES+1];
  // Shift control is only needed as an input to a stage, so no link past the last.
  logic [LOG-1:0]   link_amt   [STAGES];
  logic             link_left  [STAGES];
  logic [1:0]       link_fill  [STAGES];

  assign link_valid[0] = bus.in_valid;
  assign link_data[0]  = dec_data;
  assign link_cout[0]  = dec_cout;
  assign link_tag[0]   = bus.in_tag;
  assign link_amt[0]   = dec_amt;
  assign link_left[0]  = dec_left;
  assign link_fill[0]  = dec_fill;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = lvl_lo(gi);
      localparam int HI = lvl_lo(gi + 1);

      logic [WIDTH-1:0] data_next;
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             cout_reg;
      logic [TAG_W-1:0] tag_reg;

      // Apply this stage's share of the mux levels to the incoming partial result.
      always_comb begin
        data_next = link_data[gi];
        for (int k = LO; k < HI; k++) begin
          if (link_amt[gi][k])
            data_next = shift_level(data_next, 1 << k, link_left[gi], link_fill[gi]);
        end
      end

      // Stage register: whole pipeline advances together or holds together.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          cout_reg  <= 1'b0;
          tag_reg   <= '0;
        end else if (adv) begin
          valid_reg <= link_valid[gi];
          data_reg  <= data_next;
          cout_reg  <= link_cout[gi];
          tag_reg   <= link_tag[gi];
        end
      end

      assign link_valid[gi+1] = valid_reg;
      assign link_data[gi+1]  = data_reg;
      assign link_cout[gi+1]  = cout_reg;
      assign link_tag[gi+1]   = tag_reg;

      if (gi < STAGES - 1) begin : g_ctl
        logic [LOG-1:0] amt_reg;
        logic           left_reg;
        logic [1:0]     fill_reg;

        // Carry the shift control forward for the remaining levels.
        always_ff @(posedge clk) begin
          if (rst) begin
            amt_reg  <= '0;
            left_reg <= 1'b0;
            fill_reg <= FILL_ZERO;
          end else if (adv) begin
            amt_reg  <= link_amt[gi];
            left_reg <= link_left[gi];
            fill_reg <= link_fill[gi];
          end
        end

        assign link_amt[gi+1]  = amt_reg;
        assign link_left[gi+1] = left_reg;
        assign link_fill[gi+1] = fill_reg;
      end else begin : g_flags
        logic zero_reg;
        logic neg_reg;

        // Flags registered alongside the final result so they reset to 0.
        always_ff @(posedge clk) begin
          if (rst) begin
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
          end else if (adv) begin
            zero_reg <= (data_next == '0);
            neg_reg  <= data_next[WIDTH-1];
          end
        end

        assign bus.out_zero = zero_reg;
        assign bus.out_neg  = neg_reg;
      end
    end
  endgenerate

  assign bus.out_valid = link_valid[STAGES];
  assign bus.out_data  = link_data[STAGES];
  assign bus.out_cout  = link_cout[STAGES];
  assign bus.out_tag   = link_tag[STAGES];
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: three instances (STAGES 1, 2, 5) share
// one stimulus stream; results are compared against hand-computed values.
module tb_pipelined_shifter;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic [2:0]    in_mode;
  logic          in_cin;
  logic [TW-1:0] in_tag;
  logic          out_ready;

  pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) if1 ();
  pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) if2 ();
  pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) if5 ();

  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;  assign if5.in_valid = in_valid;
  assign if1.in_data  = in_data;   assign if2.in_data  = in_data;   assign if5.in_data  = in_data;
  assign if1.in_amt   = in_amt;    assign if2.in_amt   = in_amt;    assign if5.in_amt   = in_amt;
  assign if1.in_mode  = in_mode;   assign if2.in_mode  = in_mode;   assign if5.in_mode  = in_mode;
  assign if1.in_cin   = in_cin;    assign if2.in_cin   = in_cin;    assign if5.in_cin   = in_cin;
  assign if1.in_tag   = in_tag;    assign if2.in_tag   = in_tag;    assign if5.in_tag   = in_tag;
  assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if5.out_ready = out_ready;

  pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(1), .TAG_W(TW)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(2), .TAG_W(TW)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .STAGES(5), .TAG_W(TW)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] tag_cnt = '0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    end
  endtask

  // Present one operation with out_ready high, then collect it from all three DUTs.
  task automatic run_op(input string name, input logic [2:0] mode, input logic [W-1:0] data,
                        input logic [AW-1:0] amt, input logic cin,
                        input logic [W-1:0] exp_d, input logic exp_c);
    int            lat [3];
    logic [W-1:0]  od  [3];
    logic          oc  [3];
    logic          oz  [3];
    logic          on  [3];
    logic [TW-1:0] ot  [3];
    int            exp_lat [3];
    int            stg [3];
    logic [TW-1:0] tag;
    exp_lat = '{0, 1, 4};
    stg     = '{1, 2, 5};
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; od[i] = '0; oc[i] = 1'b0; oz[i] = 1'b0; on[i] = 1'b0; ot[i] = '0;
    end
    tag = tag_cnt;
    tag_cnt = tag_cnt + 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = mode; in_data = data; in_amt = amt; in_cin = cin; in_tag = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (if1.out_valid && lat[0] < 0) begin
        lat[0] = c; od[0] = if1.out_data; oc[0] = if1.out_cout; oz[0] = if1.out_zero; on[0] = if1.out_neg; ot[0] = if1.out_tag;
      end
      if (if2.out_valid && lat[1] < 0) begin
        lat[1] = c; od[1] = if2.out_data; oc[1] = if2.out_cout; oz[1] = if2.out_zero; on[1] = if2.out_neg; ot[1] = if2.out_tag;
      end
      if (if5.out_valid && lat[2] < 0) begin
        lat[2] = c; od[2] = if5.out_data; oc[2] = if5.out_cout; oz[2] = if5.out_zero; on[2] = if5.out_neg; ot[2] = if5.out_tag;
      end
      @(negedge clk);
    end
    $display("op %s mode=%0d in=%h n=%0d cin=%0b tag=%0d -> s2 out=%h cout=%0b", name, mode, data, amt, cin, tag, od[1], oc[1]);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s s%0d latency", name, stg[i]), 64'(lat[i]), 64'(exp_lat[i]));
      check($sformatf("%s s%0d data", name, stg[i]), 64'(od[i]), 64'(exp_d));
      check($sformatf("%s s%0d cout", name, stg[i]), 64'(oc[i]), 64'(exp_c));
      check($sformatf("%s s%0d zero", name, stg[i]), 64'(oz[i]), 64'(exp_d == '0));
      check($sformatf("%s s%0d neg", name, stg[i]), 64'(on[i]), 64'(exp_d[W-1]));
      check($sformatf("%s s%0d tag", name, stg[i]), 64'(ot[i]), 64'(tag));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  bp_exp [8];
    int            sent;
    int            rcvd;
    logic          stall_prev;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_cin = 1'b0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state, sampled while reset is still asserted
    check("rst s2 out_valid", 64'(if2.out_valid), 64'(0));
    check("rst s2 out_data", 64'(if2.out_data), 64'(0));
    check("rst s2 out_cout", 64'(if2.out_cout), 64'(0));
    check("rst s2 out_zero", 64'(if2.out_zero), 64'(0));
    check("rst s2 out_neg", 64'(if2.out_neg), 64'(0));
    check("rst s2 out_tag", 64'(if2.out_tag), 64'(0));
    check("rst s1 out_valid", 64'(if1.out_valid), 64'(0));
    check("rst s5 out_valid", 64'(if5.out_valid), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post-rst s2 in_ready", 64'(if2.in_ready), 64'(1));

    // Directed operations: name, mode, operand, amount, cin, result, carry
    run_op("lsl_n1",   3'd0, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1);
    run_op("lsr_n32",  3'd1, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
    run_op("lsr_n33",  3'd1, 32'h8000_0000, 8'd33,  1'b0, 32'h0000_0000, 1'b0);
    run_op("asr_n40",  3'd2, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1);
    run_op("ror_n4",   3'd3, 32'h0000_00F1, 8'd4,   1'b0, 32'h1000_000F, 1'b0);
    run_op("ror_n32",  3'd3, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1);
    run_op("rrx",      3'd5, 32'h0000_0003, 8'd7,   1'b1, 32'h8000_0001, 1'b1);
    run_op("lsl_n0",   3'd0, 32'h0000_1234, 8'd0,   1'b1, 32'h0000_1234, 1'b1);
    run_op("lsr_n0",   3'd1, 32'h0000_1234, 8'd0,   1'b1, 32'h0000_1234, 1'b1);
    run_op("ror_n0",   3'd3, 32'h0000_1234, 8'd0,   1'b1, 32'h0000_1234, 1'b1);
    run_op("rsv110",   3'd6, 32'h0000_1234, 8'd5,   1'b1, 32'h0000_1234, 1'b1);
    run_op("rsv111",   3'd7, 32'h0000_1234, 8'd9,   1'b0, 32'h0000_1234, 1'b0);
    run_op("lsl_n255", 3'd0, 32'h0000_0001, 8'd255, 1'b1, 32'h0000_0000, 1'b0);
    run_op("lsl_n32",  3'd0, 32'h0000_000F, 8'd32,  1'b0, 32'h0000_0000, 1'b1);
    run_op("rol_n33",  3'd4, 32'h8000_0001, 8'd33,  1'b0, 32'h0000_0003, 1'b1);
    run_op("rol_n12",  3'd4, 32'h1234_5678, 8'd12,  1'b0, 32'h4567_8123, 1'b1);
    run_op("rol_n32",  3'd4, 32'h1234_5678, 8'd32,  1'b1, 32'h1234_5678, 1'b0);
    run_op("asr_n4",   3'd2, 32'h8000_0010, 8'd4,   1'b0, 32'hF800_0001, 1'b0);
    run_op("asr_n21",  3'd2, 32'hC000_0000, 8'd21,  1'b0, 32'hFFFF_FE00, 1'b0);
    run_op("asr_n32p", 3'd2, 32'h7FFF_FFFF, 8'd32,  1'b1, 32'h0000_0000, 1'b0);
    run_op("lsr_n5",   3'd1, 32'h0000_00F0, 8'd5,   1'b0, 32'h0000_0007, 1'b1);

    // Back-pressure on the STAGES=2 instance: LSL of 1 by the tag value
    bp_exp = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80};
    sent = 0; rcvd = 0; stall_prev = 1'b0; prev_data = '0; prev_tag = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (sent < 8);
      in_mode   = 3'd0;
      in_data   = 32'h1;
      in_amt    = AW'(sent);
      in_cin    = 1'b0;
      in_tag    = TW'(sent);
      #1;
      check($sformatf("bp c%0d in_ready", c), 64'(if2.in_ready), 64'(!(if2.out_valid && !out_ready)));
      if (stall_prev) begin
        check($sformatf("bp c%0d hold data", c), 64'(if2.out_data), 64'(prev_data));
        check($sformatf("bp c%0d hold tag", c), 64'(if2.out_tag), 64'(prev_tag));
      end
      if (if2.out_valid && out_ready) begin
        $display("bp result tag=%0d data=%h cout=%0b", if2.out_tag, if2.out_data, if2.out_cout);
        check($sformatf("bp r%0d tag", rcvd), 64'(if2.out_tag), 64'(rcvd));
        check($sformatf("bp r%0d data", rcvd), 64'(if2.out_data), 64'(bp_exp[rcvd]));
        check($sformatf("bp r%0d cout", rcvd), 64'(if2.out_cout), 64'(0));
        rcvd++;
      end
      stall_prev = if2.out_valid && !out_ready;
      prev_data  = if2.out_data;
      prev_tag   = if2.out_tag;
      if (in_valid && if2.in_ready) sent++;
    end
    check("bp received count", 64'(rcvd), 64'(8));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("bp no duplicate", 64'(if2.out_valid), 64'(0));

    // Reset mid-stream: op A accepted, op B presented together with reset
    in_valid = 1'b1; in_mode = 3'd0; in_data = 32'h0000_00FF; in_amt = 8'd4; in_cin = 1'b1;
    in_tag = 4'hA; out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'h0000_0F00; in_tag = 4'hB; rst = 1'b1;
    @(negedge clk);
    $display("reset issued with ops tag A and B in flight");
    check("midrst s1 out_valid", 64'(if1.out_valid), 64'(0));
    check("midrst s2 out_valid", 64'(if2.out_valid), 64'(0));
    check("midrst s5 out_valid", 64'(if5.out_valid), 64'(0));
    check("midrst s1 outputs", 64'({if1.out_data, if1.out_cout, if1.out_zero, if1.out_neg, if1.out_tag}), 64'(0));
    check("midrst s2 outputs", 64'({if2.out_data, if2.out_cout, if2.out_zero, if2.out_neg, if2.out_tag}), 64'(0));
    check("midrst s5 outputs", 64'({if5.out_data, if5.out_cout, if5.out_zero, if5.out_neg, if5.out_tag}), 64'(0));
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midrst c%0d no emerge", c),
            64'({if1.out_valid, if2.out_valid, if5.out_valid}), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
